// File: rtl/freq_meter.sv
// freq_meter: counts synchronized rising edges of sig_i over a GATE_CYCLES window and reports the count.
module freq_meter #(
  parameter int GATE_CYCLES = 100_000_000,
  parameter int CNT_W = 27
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sig_i,
  input  logic             start_i,
  input  logic             cont_i,
  output logic [CNT_W-1:0] freq_o,
  output logic             valid_o,
  output logic             ovf_o,
  output logic             busy_o
);
  localparam int GW = $clog2(GATE_CYCLES);
  typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;
  state_t state;
  logic s1, s2, s3, rise, full, last, sat, sat_next;
  logic [GW-1:0] gate_cnt;
  logic [CNT_W-1:0] cnt, cnt_next;
  always_comb begin
    rise = s2 & ~s3;
    full = &cnt;
    last = gate_cnt == GW'(GATE_CYCLES - 1);
    cnt_next = (rise && !full) ? cnt + 1'b1 : cnt;
    sat_next = sat | (rise & full);
  end
  // the final-cycle edge is folded in via cnt_next/sat_next when latching the result
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      {s1, s2, s3} <= '0;
      gate_cnt <= '0;
      cnt <= '0;
      sat <= 1'b0;
      freq_o <= '0;
      valid_o <= 1'b0;
      ovf_o <= 1'b0;
      busy_o <= 1'b0;
    end else begin
      {s1, s2, s3} <= {sig_i, s1, s2};
      valid_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          state <= GATE;
          busy_o <= 1'b1;
          gate_cnt <= '0;
          cnt <= '0;
          sat <= 1'b0;
        end
        GATE: begin
          gate_cnt <= gate_cnt + 1'b1;
          cnt <= cnt_next;
          sat <= sat_next;
          if (last) begin
            state <= DONE;
            busy_o <= 1'b0;
            valid_o <= 1'b1;
            freq_o <= cnt_next;
            ovf_o <= sat_next;
          end
        end
        DONE: begin
          state <= cont_i ? GATE : IDLE;
          busy_o <= cont_i;
          gate_cnt <= '0;
          cnt <= '0;
          sat <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: scoreboard bench over three configurations (basic/continuous, saturation, window boundary).
module tb_freq_meter;
  typedef struct {
    longint cyc;
    longint f;
    bit o;
  } exp_t;
  logic clk = 1'b0;
  longint cyc = 0;
  int n_chk = 0, n_fail = 0;
  exp_t qa[$], qs[$], qb[$];
  logic rst_a, rst_x;
  logic sig_a, start_a, cont_a, valid_a, ovf_a, busy_a;
  logic [26:0] freq_a;
  logic sig_s, start_s, valid_s, ovf_s, busy_s;
  logic [3:0] freq_s;
  logic sig_b, start_b, valid_b, ovf_b, busy_b;
  logic [26:0] freq_b;
  int per_a = 0, per_s = 0, ph = 0;
  freq_meter #(.GATE_CYCLES(100), .CNT_W(27)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .sig_i(sig_a), .start_i(start_a), .cont_i(cont_a),
    .freq_o(freq_a), .valid_o(valid_a), .ovf_o(ovf_a), .busy_o(busy_a));
  freq_meter #(.GATE_CYCLES(100), .CNT_W(4)) dut_s (
    .clk_i(clk), .rst_i(rst_x), .sig_i(sig_s), .start_i(start_s), .cont_i(1'b0),
    .freq_o(freq_s), .valid_o(valid_s), .ovf_o(ovf_s), .busy_o(busy_s));
  freq_meter #(.GATE_CYCLES(10), .CNT_W(27)) dut_b (
    .clk_i(clk), .rst_i(rst_x), .sig_i(sig_b), .start_i(start_b), .cont_i(1'b0),
    .freq_o(freq_b), .valid_o(valid_b), .ovf_o(ovf_b), .busy_o(busy_b));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, req, cyc);
    end
  endtask
  task automatic score(input string n, input bit has, input exp_t e, input longint f, input bit o);
    if (!has) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_unexpected_valid: got freq %0d with no pending result (cycle %0d)", n, f, cyc);
    end else begin
      chk({n, "_valid_cycle"}, cyc, e.cyc);
      chk({n, "_freq"}, f, e.f);
      chk({n, "_ovf"}, longint'(o), longint'(e.o));
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    e = '{0, 0, 1'b0};
    if (valid_a) begin
      if (qa.size() != 0) begin e = qa.pop_front(); score("a", 1'b1, e, longint'(freq_a), ovf_a); end
      else score("a", 1'b0, e, longint'(freq_a), ovf_a);
    end
    if (valid_s) begin
      if (qs.size() != 0) begin e = qs.pop_front(); score("s", 1'b1, e, longint'(freq_s), ovf_s); end
      else score("s", 1'b0, e, longint'(freq_s), ovf_s);
    end
    if (valid_b) begin
      if (qb.size() != 0) begin e = qb.pop_front(); score("b", 1'b1, e, longint'(freq_b), ovf_b); end
      else score("b", 1'b0, e, longint'(freq_b), ovf_b);
    end
  end
  initial forever begin
    @(negedge clk);
    ph++;
    sig_a = per_a != 0 && (ph % per_a) < per_a / 2;
    sig_s = per_s != 0 && (ph % per_s) < per_s / 2;
  end
  task automatic go_a(output longint c);
    start_a = 1'b1;
    c = cyc;
    @(negedge clk);
    start_a = 1'b0;
  endtask
  task automatic go_s(input longint f, input bit o);
    start_s = 1'b1;
    qs.push_back('{cyc + 101, f, o});
    @(negedge clk);
    start_s = 1'b0;
  endtask
  task automatic bnd(input int off, input longint f);
    if (off < 0) begin
      sig_b = 1'b1;
      repeat (-off) @(negedge clk);
    end
    start_b = 1'b1;
    qb.push_back('{cyc + 11, f, 1'b0});
    @(negedge clk);
    start_b = 1'b0;
    if (off > 0) begin
      repeat (off - 1) @(negedge clk);
      sig_b = 1'b1;
    end
    repeat (15) @(negedge clk);
    sig_b = 1'b0;
    repeat (5) @(negedge clk);
  endtask
  initial begin
    longint c;
    rst_a = 1'b1; rst_x = 1'b1;
    start_a = 1'b0; start_s = 1'b0; start_b = 1'b0; cont_a = 1'b0; sig_b = 1'b0;
    per_a = 2; per_s = 2;
    repeat (3) @(negedge clk);
    chk("rst_freq_a", longint'(freq_a), 0);
    chk("rst_valid_a", longint'(valid_a), 0);
    chk("rst_ovf_a", longint'(ovf_a), 0);
    chk("rst_busy_a", longint'(busy_a), 0);
    chk("rst_freq_s", longint'(freq_s), 0);
    chk("rst_busy_b", longint'(busy_b), 0);
    rst_a = 1'b0; rst_x = 1'b0;
    per_a = 10;
    repeat (20) @(negedge clk);
    chk("idle_busy_a", longint'(busy_a), 0);
    chk("idle_busy_s", longint'(busy_s), 0);
    // single shot: period 10 gives exactly 10 rises in any 100 consecutive cycles
    go_a(c);
    qa.push_back('{c + 101, 10, 1'b0});
    chk("busy_first", longint'(busy_a), 1);
    repeat (99) @(negedge clk);
    chk("busy_last", longint'(busy_a), 1);
    @(negedge clk);
    chk("busy_done", longint'(busy_a), 0);
    repeat (5) @(negedge clk);
    chk("busy_after", longint'(busy_a), 0);
    chk("freq_hold", longint'(freq_a), 10);
    go_a(c);
    qa.push_back('{c + 101, 10, 1'b0});
    repeat (40) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (70) @(negedge clk);
    per_a = 4;
    repeat (10) @(negedge clk);
    cont_a = 1'b1;
    go_a(c);
    qa.push_back('{c + 101, 25, 1'b0});
    qa.push_back('{c + 202, 25, 1'b0});
    qa.push_back('{c + 303, 25, 1'b0});
    repeat (249) @(negedge clk);
    cont_a = 1'b0;
    repeat (70) @(negedge clk);
    chk("cont_idle_busy", longint'(busy_a), 0);
    repeat (120) @(negedge clk);
    per_a = 10;
    repeat (10) @(negedge clk);
    go_a(c);
    repeat (49) @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    chk("abort_freq", longint'(freq_a), 0);
    chk("abort_busy", longint'(busy_a), 0);
    repeat (150) @(negedge clk);
    chk("abort_freq_hold", longint'(freq_a), 0);
    go_a(c);
    qa.push_back('{c + 101, 10, 1'b0});
    repeat (110) @(negedge clk);
    go_s(15, 1'b1);
    repeat (110) @(negedge clk);
    per_s = 0;
    repeat (10) @(negedge clk);
    go_s(0, 1'b0);
    repeat (110) @(negedge clk);
    bnd(-2, 0);
    bnd(-1, 1);
    bnd(8, 1);
    bnd(9, 0);
    chk("pending_a", longint'(qa.size()), 0);
    chk("pending_s", longint'(qs.size()), 0);
    chk("pending_b", longint'(qb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/freq_meter.md
# freq_meter

Gated frequency meter: counts rising edges of an asynchronous input `sig_i` over a fixed window of `GATE_CYCLES` system clocks and reports the count as a binary frequency word. It is the measuring end of the board's clock-divider chain. It verifies divider outputs (e.g. the 2 Hz blink clock) on hardware and feeds the display driver. It supports single-shot and continuous measurement.

## Interface
- `GATE_CYCLES`, default 100_000_000: gate window length in `clk_i` cycles (1 s at 100 MHz); legal range ≥ 2.
- `CNT_W`, default 27: width of edge counter and result.
- `clk_i`  in  1  system clock, 100 MHz on board.
- `rst_i`  in  1  synchronous, active-high reset. One clock; all state changes only on `posedge clk_i`.
- `sig_i`  in  1  signal under measurement; asynchronous to `clk_i`.
- `start_i`  in  1  single-cycle request to begin a measurement (ignored while busy).
- `cont_i`  in  1  1 = continuous mode (new window starts immediately after each result); sampled at window end.
- `freq_o`  out  CNT_W  last completed result (edges per window).
- `valid_o`  out  1  one-cycle pulse when `freq_o` updates.
- `ovf_o`  out  1  last result saturated.
- `busy_o`  out  1  gate window in progress.

## Operation
- Input path: `sig_i` → 2-flop synchronizer → delay flop; rising edge `edge = s2 & ~s3`.
- FSM states: IDLE, GATE, DONE.
  - IDLE: `busy_o`=0. `start_i`=1 → GATE; clear gate counter and edge counter in the same cycle.
  - GATE: `busy_o`=1. Gate counter increments every cycle. Each cycle with `edge`=1 increments the edge counter, saturating at 2^CNT_W−1. When the gate counter == GATE_CYCLES−1 → DONE. The edge in that final cycle is counted.
  - DONE (1 cycle): latch `freq_o` ← final edge count and `ovf_o` ← saturation flag. Pulse `valid_o`=1. Then:
    - if `cont_i`=1 → GATE with counters cleared;
    - else → IDLE.
- Saturation: once the edge counter reaches all-ones it holds. The internal sat flag sets when an increment is attempted at all-ones.
- `start_i` asserted in GATE or DONE is ignored; no queuing.
- `cont_i` deasserted mid-window: the current window completes normally, then the FSM returns to IDLE.
- Edges are counted as the first GATE cycle onward; a synchronized edge arriving on the `start_i` cycle itself is not counted.
- The synchronizer runs continuously, independent of FSM state.

## Timing
- Reset values:
  - `freq_o`=0, `valid_o`=0, `ovf_o`=0, `busy_o`=0;
  - FSM=IDLE;
  - synchronizer flops=0;
  - counters=0.
- Reset mid-window aborts the window: no `valid_o`, and `freq_o` is cleared to 0.
- `start_i` sampled high in cycle t:
  - `busy_o`=1 from t+1 through t+GATE_CYCLES;
  - DONE in cycle t+GATE_CYCLES+1, with `valid_o`, `freq_o`, and `ovf_o` all updated at that edge (registered outputs).
- Continuous mode:
  - consecutive `valid_o` pulses are exactly GATE_CYCLES+1 cycles apart;
  - the DONE cycle is a dead cycle whose edges are not counted.
- Edge-detect latency: a `sig_i` rise meeting setup before edge k is seen as `edge` in cycle k+2.
- Maximum countable rate is one edge per 2 clocks; `sig_i` toggling faster aliases, which is not a spec violation.
- `freq_o` holds its value between `valid_o` pulses.

## Test plan
- Reset/idle: assert `rst_i` 3 cycles with `sig_i` toggling → all outputs 0, `busy_o` stays 0 with no `start_i`.
- Basic count, `GATE_CYCLES`=100, `sig_i` period 10 clocks, single-shot:
  - `start_i` at t → `valid_o` at t+101 with `freq_o`=10 (±1 by phase), `ovf_o`=0;
  - `busy_o` low after.
- Continuous, `GATE_CYCLES`=100, `sig_i` period 4 clocks:
  - three `valid_o` pulses spaced 101 cycles, each `freq_o` in 24..26;
  - drop `cont_i` during the 3rd window → exactly 3 pulses, then IDLE.
- Saturation, `CNT_W`=4, `GATE_CYCLES`=100, `sig_i` period 2 → `freq_o`=15, `ovf_o`=1.
  - Next window with `sig_i`=0 → `freq_o`=0, `ovf_o`=0.
- Boundary edges, `GATE_CYCLES`=10: a single synchronized edge placed in the last GATE cycle → `freq_o`=1. The same edge placed in the DONE cycle → not counted, `freq_o`=0.
- Abort and busy: `start_i` pulsed again mid-window → no effect on timing. `rst_i` at window midpoint → no `valid_o`, `freq_o`=0, and a fresh `start_i` works normally.
